// File: rtl/output_port.sv
// Output stage of the Nano datapath: captures ULA results on LdOUTPUT into a small
// first-word-fall-through FIFO and presents them to a consumer over valid/ready.
module output_port #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             LdOUTPUT,
  input  logic [WIDTH-1:0] DataIn,
  input  logic             OutReady,
  input  logic             ClrOvf,
  output logic [WIDTH-1:0] OutData,
  output logic             OutValid,
  output logic             Full,
  output logic             Empty,
  output logic [AW:0]      Count,
  output logic             Overflow
);

  localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);
  localparam logic [AW:0] OneCnt  = (AW + 1)'(1);

  typedef enum logic [0:0] {StIdle, StPresent} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, rp_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             full, pop, push_ok, drop;

  assign full    = (cnt_q == FullCnt);
  assign pop     = OutValid & OutReady;
  // A full buffer still accepts a write when the head leaves in the same cycle.
  assign push_ok = LdOUTPUT & (~full | pop);
  assign drop    = LdOUTPUT & full & ~pop;

  always_comb begin
    cnt_d = cnt_q;
    if (push_ok && !pop) begin
      cnt_d = cnt_q + OneCnt;
    end else if (pop && !push_ok) begin
      cnt_d = cnt_q - OneCnt;
    end
  end

  // Drop wins over clear so a write lost in the clearing cycle is not hidden.
  always_comb begin
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ClrOvf) begin
      ovf_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (push_ok) state_d = StPresent;
      end
      StPresent: begin
        if (pop && !push_ok && cnt_q == OneCnt) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      if (push_ok) begin
        mem_q[wp_q] <= DataIn;
        wp_q        <= wp_q + AW'(1);
      end
      if (pop) begin
        rp_q <= rp_q + AW'(1);
      end
    end
  end

  assign OutValid = (state_q == StPresent);
  assign OutData  = mem_q[rp_q];
  assign Full     = full;
  assign Empty    = (cnt_q == '0);
  assign Count    = cnt_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_output_port.sv
// Directed bench for output_port: stimulus queues expected values, a negedge monitor
// checks every handshake against that queue; flags are checked after each edge.
module tb_output_port;

  logic       clk;
  logic       rst;
  logic       LdOUTPUT;
  logic [7:0] DataIn;
  logic       OutReady;
  logic       ClrOvf;
  logic [7:0] OutData;
  logic       OutValid;
  logic       Full;
  logic       Empty;
  logic [2:0] Count;
  logic       Overflow;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [7:0] expq [$];

  output_port #(.WIDTH(8), .DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .LdOUTPUT (LdOUTPUT),
    .DataIn   (DataIn),
    .OutReady (OutReady),
    .ClrOvf   (ClrOvf),
    .OutData  (OutData),
    .OutValid (OutValid),
    .Full     (Full),
    .Empty    (Empty),
    .Count    (Count),
    .Overflow (Overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply inputs for one cycle; returns 1 time unit after the rising edge.
  task automatic cyc(input logic ld, input logic [7:0] d, input logic rdy, input logic clr);
    LdOUTPUT = ld;
    DataIn   = d;
    OutReady = rdy;
    ClrOvf   = clr;
    @(posedge clk);
    #1;
    LdOUTPUT = 1'b0;
    OutReady = 1'b0;
    ClrOvf   = 1'b0;
  endtask

  // Monitor: a handshake seen mid-cycle completes at the next rising edge.
  always @(negedge clk) begin
    if (rst && OutValid && OutReady) begin
      if (expq.size() == 0) begin
        chk("unexpected_pop", {24'd0, OutData}, 32'hFFFF_FFFF);
      end else begin
        chk("pop_data", {24'd0, OutData}, {24'd0, expq.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; LdOUTPUT = 1'b0; DataIn = '0; OutReady = 1'b0; ClrOvf = 1'b0;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Reset then idle.
    chk("rst_outdata", {24'd0, OutData}, 32'h00);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      chk("idle_empty", {31'd0, Empty}, 32'd1);
      chk("idle_valid", {31'd0, OutValid}, 32'd0);
      chk("idle_count", {29'd0, Count}, 32'd0);
      chk("idle_ovf", {31'd0, Overflow}, 32'd0);
    end

    // Single transfer with the consumer stalled for 3 cycles.
    cyc(1'b1, 8'h5A, 1'b0, 1'b0); expq.push_back(8'h5A);
    chk("single_valid", {31'd0, OutValid}, 32'd1);
    chk("single_count", {29'd0, Count}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("single_hold", {24'd0, OutData}, 32'h5A);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("single_empty", {31'd0, Empty}, 32'd1);

    // Fill and overflow: 05 is dropped.
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0);
      if (i <= 4) expq.push_back(8'(i));
      if (i == 4) begin
        chk("fill_full", {31'd0, Full}, 32'd1);
        chk("fill_ovf_pre", {31'd0, Overflow}, 32'd0);
      end
    end
    chk("fill_count", {29'd0, Count}, 32'd4);
    chk("fill_ovf", {31'd0, Overflow}, 32'd1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fill_drained", {31'd0, Empty}, 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("fill_ovf_clr", {31'd0, Overflow}, 32'd0);

    // Full with simultaneous push and pop.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0); expq.push_back(8'h10 + 8'(i));
    end
    cyc(1'b1, 8'h14, 1'b1, 1'b0); expq.push_back(8'h14);
    chk("pp_count", {29'd0, Count}, 32'd4);
    chk("pp_ovf", {31'd0, Overflow}, 32'd0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pp_drained", {31'd0, Empty}, 32'd1);

    // Pointer wrap with sustained push+pop.
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 8'hA0 + 8'(i), 1'b1, 1'b0); expq.push_back(8'hA0 + 8'(i));
      chk("wrap_count", {29'd0, Count}, 32'd1);
      chk("wrap_head", {24'd0, OutData}, {24'd0, 8'hA0 + 8'(i)});
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("wrap_empty", {31'd0, Empty}, 32'd1);

    // Overflow clear priority, then asynchronous reset with data buffered.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0); expq.push_back(8'hC0 + 8'(i));
    end
    cyc(1'b1, 8'hC4, 1'b0, 1'b0);
    chk("ovf_set", {31'd0, Overflow}, 32'd1);
    cyc(1'b1, 8'hC5, 1'b0, 1'b1);
    chk("ovf_drop_clr", {31'd0, Overflow}, 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr", {31'd0, Overflow}, 32'd0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pre_rst_count", {29'd0, Count}, 32'd3);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", {31'd0, OutValid}, 32'd0);
    chk("arst_count", {29'd0, Count}, 32'd0);
    chk("arst_empty", {31'd0, Empty}, 32'd1);
    chk("arst_data", {24'd0, OutData}, 32'h00);
    expq.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_valid", {31'd0, OutValid}, 32'd0);

    chk("leftover_expected", expq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/output_port.md
# output_port

Output stage of the Nano datapath. Captures the 8-bit value presented on the ULA result bus whenever the control unit pulses `LdOUTPUT` (the OUTPUT instruction). Buffers up to `DEPTH` values in a small FIFO and hands them to an external consumer over a valid/ready handshake. The control unit has no stall input, so the block never back-pressures it: writes to a full buffer are dropped and flagged.

## Interface
- `WIDTH`, 8, data width; matches the ULA result bus.
- `DEPTH`, 4, number of buffer entries; power of 2, at least 2.
- `AW`, log2(`DEPTH`), pointer width; derived, not overridden.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `LdOUTPUT`  in  1  write strobe from the control unit; one write per cycle it is high.
- `DataIn`  in  `WIDTH`  value to capture (ULA result).
- `OutReady`  in  1  consumer can accept `OutData` this cycle.
- `ClrOvf`  in  1  clears the sticky `Overflow` flag.
- `OutData`  out  `WIDTH`  head-of-buffer value.
- `OutValid`  out  1  `OutData` is valid (buffer not empty).
- `Full`  out  1  buffer holds `DEPTH` entries.
- `Empty`  out  1  buffer holds 0 entries.
- `Count`  out  `AW`+1  number of entries held, 0..`DEPTH`.
- `Overflow`  out  1  sticky flag: at least one write was dropped.

## Operation
- Storage: `DEPTH` x `WIDTH` register array, write pointer `wp`, read pointer `rp` (`AW` bits, wrap modulo `DEPTH`), occupancy `cnt` (`AW`+1 bits).
- Push request: `LdOUTPUT`=1. Pop: `OutValid`=1 and `OutReady`=1.
- Push accepted when `cnt` < `DEPTH`, or when `cnt` == `DEPTH` and a pop occurs in the same cycle. On accept: mem[`wp`] <= `DataIn`, `wp` <= `wp`+1.
- Pop: `rp` <= `rp`+1.
- `cnt`: +1 on accepted push without pop; -1 on pop without push; unchanged on push+pop or idle.
- Dropped push (full, no pop): storage, pointers and `cnt` unchanged; `Overflow` <= 1.
- `Overflow` stays set until `ClrOvf`=1. A drop in the same cycle as `ClrOvf` leaves it set.
- Push when empty: no pop is possible that cycle (`OutValid`=0), so the entry is stored.
- Handshake states: IDLE (`cnt`=0, `OutValid`=0) and PRESENT (`cnt`>0, `OutValid`=1).
  - IDLE goes to PRESENT on an accepted push.
  - PRESENT goes to IDLE on a pop with no push when `cnt`=1.
  - Otherwise the state is unchanged.
- While `OutValid`=1 and `OutReady`=0, `OutData` stays stable. Pushes do not disturb the head entry.
- `OutData` = mem[`rp`] (first-word fall-through). It is don't-care while `OutValid`=0.
- `Full` = (`cnt`==`DEPTH`), `Empty` = (`cnt`==0), `OutValid` = !`Empty`, `Count` = `cnt`.

## Timing
- Reset (`rst`=0, asynchronous): `wp`=`rp`=0, `cnt`=0, `Overflow`=0. Outputs: `OutValid`=0, `Empty`=1, `Full`=0, `Count`=0, `OutData`=0 (array cleared). Asserting reset mid-transfer discards all buffered data immediately.
- Write latency: push sampled at edge N. `OutValid`/`Count`/`Full` reflect it after edge N, so the consumer can pop at edge N+1.
- Pop takes effect at the edge where `OutValid`&`OutReady`=1. The next entry appears on `OutData` after that edge, giving 1 entry per cycle at sustained `OutReady`=1.
- The control unit pulses `LdOUTPUT` for exactly one cycle per OUTPUT instruction (minimum 4 cycles apart). The block does not depend on this: back-to-back pushes are legal.
- No combinational path from `OutReady` to `OutValid` or `OutData`.

## Test plan
- Reset then idle: `rst` low for 2 cycles, release -> `Empty`=1, `OutValid`=0, `Count`=0, `Overflow`=0 for 10 cycles.
- Single transfer: push 8'h5A with `OutReady`=0 -> next cycle `OutValid`=1, `OutData`=8'h5A, `Count`=1. Hold 3 cycles with data stable, then `OutReady`=1 for 1 cycle -> `Empty`=1.
- Fill and overflow (`DEPTH`=4): push 8'h01..8'h05 back-to-back, `OutReady`=0 -> `Full`=1 after 4th push, `Count`=4, `Overflow`=1. Drain yields 01,02,03,04 in order, 05 absent.
- Full with simultaneous push+pop: buffer full with 10,11,12,13; push 8'h14 with `OutReady`=1 -> 10 popped, 14 stored, `Count`=4, `Overflow` unchanged. Drain gives 11,12,13,14.
- Pointer wrap: 10 cycles of push+pop at `OutReady`=1 with values 8'hA0..8'hA9 -> each value emitted one cycle after its push, in order, `Count` never exceeds 1.
- Overflow clear and reset mid-operation: set `Overflow`, then pulse `ClrOvf` in the same cycle as a dropped push -> `Overflow` stays 1. `ClrOvf` alone -> 0. With 3 entries buffered, assert `rst` asynchronously mid-cycle -> `OutValid`=0, `Count`=0 immediately.
